fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Holds the program counter (PC) and the instruction register (IR), and supplies the 4-bit Opcode and decoded instruction fields to the multicycle Control FSM.
- Consumes Control's PCWrite, PCWriteCond, PCSource and IRWrite strobes, and evaluates the branch condition from the ALU Zero flag.
- Keeps saturating performance counters for instructions fetched, branches executed and branches taken, plus a sticky illegal-PCSource flag.
- Sits between Control/datapath and instruction memory.

Parameters:
- DW, 16, datapath/instruction width
- PC_RESET, 16'h0000, PC value loaded on reset
- CW, 16, performance counter width

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- PCWrite  in  1  unconditional PC load strobe
- PCWriteCond  in  1  conditional PC load strobe (branch)
- PCSource  in  2  next-PC select: 0=ALUResult, 1=ALUOut, 2=JumpReg, 3=illegal
- IRWrite  in  1  latch MemData into IR
- MemData  in  DW  instruction memory read data
- ALUResult  in  DW  combinational ALU output
- ALUOut  in  DW  registered ALU output
- JumpReg  in  DW  register-file value for jalr
- Zero  in  1  ALU zero flag
- CntClear  in  1  synchronous clear of the performance counters
- PC  out  DW  current program counter
- IR  out  DW  current instruction
- Opcode  out  4  IR[15:12], to Control
- Rd, Rs  out  4 each  IR[11:8], IR[7:4]
- Imm  out  DW  IR[7:0] sign-extended to DW
- BranchTaken  out  1  registered 1-cycle pulse when a conditional PC load occurred
- InstrCount, BranchCount, TakenCount  out  CW each  saturating counters
- BadSource  out  1  sticky: a PC load was attempted with PCSource=3

Behaviour:
- Reset (RST=0, async): PC=PC_RESET, IR=0, BranchTaken=0, all counters=0, BadSource=0. Opcode/Rd/Rs/Imm follow IR, so all are 0.
- Reset mid-instruction: state is discarded immediately; the first rising edge after RST deasserts behaves normally.
- Next-PC mux (combinational): NPC = ALUResult / ALUOut / JumpReg for PCSource 0/1/2.
- load = PCWrite | (PCWriteCond & Zero).
- If load and PCSource!=3: PC<=NPC on the next edge. Latency is 1 cycle; PC is visible the cycle after the strobe.
- If load and PCSource==3: PC holds and BadSource<=1. BadSource clears only on reset.
- PCWrite and PCWriteCond asserted together: PCWrite dominates, so PC loads regardless of Zero. Both counters below still update from PCWriteCond.
- PCWriteCond without PCWrite:
  - BranchCount increments.
  - If Zero=1: PC loads, TakenCount increments, and BranchTaken=1 for exactly the following cycle.
- IRWrite=1: IR<=MemData on the edge.
  - IRWrite and PCWrite in the same cycle (Fetch): IR captures MemData addressed by the old PC and PC takes the new value. There is no interaction.
  - InstrCount increments per IRWrite cycle.
- IR holds while IRWrite=0. Opcode stays stable across Decode through writeback.
- Counters saturate at all-ones with no wrap.
- CntClear forces counters to 0 and has priority over increments in the same cycle.
- All arithmetic for PC targets is done outside the block. PC width equals DW, with no truncation.

Decomposition:
- Shared package (cpu_pkg):
  - DW
  - PCSource encodings PCSRC_ALU=0, PCSRC_ALUOUT=1, PCSRC_JREG=2
  - Opcode field bit positions
  - Opcode constants (e.g. OP_BRANCH=9, OP_JUMP=12, OP_JALR=13) shared with Control
- One natural sub-module: sat_counter (width param; inc, clr; saturating), instantiated three times.

Test Plan:
- Reset: hold RST=0 mid-run with PC=16'h0040 -> PC=16'h0000, IR=0, counters 0, BadSource 0 immediately (async).
- Fetch: MemData=16'h9A35, IRWrite=1, PCWrite=1, PCSource=0, ALUResult=16'h0002 -> next cycle IR=16'h9A35, Opcode=9, Rd=4'hA, Rs=4'h3, Imm=16'h0035, PC=16'h0002, InstrCount=1.
- Branch taken vs not: PCWriteCond=1, PCSource=1, ALUOut=16'h0010:
  - Zero=1 -> PC=16'h0010, BranchTaken pulses 1 cycle, TakenCount=1.
  - Zero=0 -> PC unchanged, BranchCount=2, TakenCount=1.
- Jalr/illegal source:
  - PCWrite=1, PCSource=2, JumpReg=16'h1234 -> PC=16'h1234.
  - PCWrite=1, PCSource=3 -> PC holds and BadSource=1 until reset.
- Saturation/clear: preload InstrCount=16'hFFFF, assert IRWrite -> stays 16'hFFFF. CntClear together with IRWrite -> InstrCount=0.
- Imm sign extension: IR=16'h40F0 -> Imm=16'hFFF0, Opcode=4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, next-PC select codes,
// instruction field positions and opcode values shared with Control.
package cpu_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JREG   = 2'd2,
    PCSRC_BAD    = 2'd3
  } pc_src_e;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int IMM_MSB = 7;

  // Opcodes decoded by Control
  localparam logic [3:0] OP_BRANCH = 4'd9;
  localparam logic [3:0] OP_JUMP   = 4'd12;
  localparam logic [3:0] OP_JALR   = 4'd13;

endpackage

// File: rtl/fetch_pc_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         RST,
  input  logic         Inc,
  input  logic         Clr,
  output logic [W-1:0] Count
);

  // Count up until all-ones, then hold; clear has priority
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST)                 Count <= '0;
    else if (Clr)             Count <= '0;
    else if (Inc && ~&Count)  Count <= Count + W'(1);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction register for the multicycle CPU.
// Selects the next PC, evaluates branch conditions, decodes IR fields
// and keeps fetch/branch performance counters.
module fetch_pc_unit #(
  parameter int            DW       = cpu_pkg::DW,
  parameter logic [DW-1:0] PC_RESET = '0,
  parameter int            CW       = 16
) (
  input  logic          Clk,
  input  logic          RST,
  input  logic          PCWrite,
  input  logic          PCWriteCond,
  input  logic [1:0]    PCSource,
  input  logic          IRWrite,
  input  logic [DW-1:0] MemData,
  input  logic [DW-1:0] ALUResult,
  input  logic [DW-1:0] ALUOut,
  input  logic [DW-1:0] JumpReg,
  input  logic          Zero,
  input  logic          CntClear,
  output logic [DW-1:0] PC,
  output logic [DW-1:0] IR,
  output logic [3:0]    Opcode,
  output logic [3:0]    Rd,
  output logic [3:0]    Rs,
  output logic [DW-1:0] Imm,
  output logic          BranchTaken,
  output logic [CW-1:0] InstrCount,
  output logic [CW-1:0] BranchCount,
  output logic [CW-1:0] TakenCount,
  output logic          BadSource
);
  import cpu_pkg::*;

  logic          condMet;
  logic          load;
  logic          srcBad;
  logic [DW-1:0] nextPc;

  assign condMet = PCWriteCond & Zero;
  assign load    = PCWrite | condMet;
  assign srcBad  = (PCSource == PCSRC_BAD);

  // Next-PC select; the illegal code never reaches the PC register
  always_comb begin
    nextPc = ALUResult;
    case (PCSource)
      PCSRC_ALU:    nextPc = ALUResult;
      PCSRC_ALUOUT: nextPc = ALUOut;
      PCSRC_JREG:   nextPc = JumpReg;
      default:      nextPc = PC;
    endcase
  end

  // PC update, illegal-source flag and branch-taken pulse
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      PC          <= PC_RESET;
      BadSource   <= 1'b0;
      BranchTaken <= 1'b0;
    end else begin
      if (load && !srcBad) PC <= nextPc;
      if (load && srcBad)  BadSource <= 1'b1;
      BranchTaken <= condMet;
    end
  end

  // Instruction register; holds between fetches so decode fields stay stable
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST)         IR <= '0;
    else if (IRWrite) IR <= MemData;
  end

  assign Opcode = IR[OP_MSB:OP_LSB];
  assign Rd     = IR[RD_MSB:RD_LSB];
  assign Rs     = IR[RS_MSB:RS_LSB];
  assign Imm    = {{(DW-8){IR[IMM_MSB]}}, IR[IMM_MSB:0]};

  sat_counter #(.W(CW)) uInstrCnt (
    .Clk(Clk), .RST(RST), .Inc(IRWrite), .Clr(CntClear), .Count(InstrCount)
  );

  sat_counter #(.W(CW)) uBranchCnt (
    .Clk(Clk), .RST(RST), .Inc(PCWriteCond), .Clr(CntClear), .Count(BranchCount)
  );

  sat_counter #(.W(CW)) uTakenCnt (
    .Clk(Clk), .RST(RST), .Inc(condMet), .Clr(CntClear), .Count(TakenCount)
  );

endmodule
